// File: rtl/register_file_if.sv
// Issue/read/commit bundle between the register file, instruction fetch and the ROB.
// Zero-latency wires; rdy_in is the only stall and freezes the register file.
interface register_file_if #(
  parameter int ROB_WIDTH = 4
);
  logic                 rdy_in;
  logic                 clear_signal;
  logic                 issue_signal;
  logic [4:0]           issue_rd_id;
  logic [ROB_WIDTH-1:0] issue_tag;
  logic [4:0]           rs1_id;
  logic [4:0]           rs2_id;
  logic [31:0]          rs1_value;
  logic [31:0]          rs2_value;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic [ROB_WIDTH-1:0] rs1_tag;
  logic [ROB_WIDTH-1:0] rs2_tag;
  logic                 reg_done;
  logic [31:0]          reg_value;
  logic [4:0]           reg_id;
  logic [ROB_WIDTH-1:0] reg_tag;

  modport master (
    output rdy_in, clear_signal, issue_signal, issue_rd_id, issue_tag,
           rs1_id, rs2_id, reg_done, reg_value, reg_id, reg_tag,
    input  rs1_value, rs2_value, rs1_busy, rs2_busy, rs1_tag, rs2_tag
  );

  modport slave (
    input  rdy_in, clear_signal, issue_signal, issue_rd_id, issue_tag,
           rs1_id, rs2_id, reg_done, reg_value, reg_id, reg_tag,
    output rs1_value, rs2_value, rs1_busy, rs2_busy, rs1_tag, rs2_tag
  );
endinterface

// File: rtl/register_file.sv
// 32x32 architectural register file with ROB rename tags; combinational reads, 1-cycle updates,
// everything frozen while rdy_in is low. RF_COMMIT_BYPASS_EN forwards a same-cycle commit to reads.
module register_file #(
  parameter int ROB_WIDTH = 4,
  parameter int REG_COUNT = 32
) (
  input logic            clk_in,
  input logic            rst_in,
  register_file_if.slave rf
);

  typedef struct packed {
    logic [31:0]          value;
    logic                 busy;
    logic [ROB_WIDTH-1:0] tag;
  } rd_port_t;

  logic [31:0]          value_q [REG_COUNT];
  logic [31:0]          value_d [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q;
  logic [REG_COUNT-1:0] busy_d;
  logic [ROB_WIDTH-1:0] tag_q   [REG_COUNT];
  logic [ROB_WIDTH-1:0] tag_d   [REG_COUNT];

  logic     commit_en;
  logic     issue_en;
  logic     clear_en;
  logic [4:0] rs_id [2];
  rd_port_t   rd    [2];

  assign commit_en = rf.rdy_in && rf.reg_done && (rf.reg_id != 5'd0);
  assign clear_en  = rf.rdy_in && rf.clear_signal;
  assign issue_en  = rf.rdy_in && rf.issue_signal && !rf.clear_signal && (rf.issue_rd_id != 5'd0);

  // Commit first, then clear/issue override busy/tag; this gives issue priority over a
  // matching commit on the same register without an explicit compare.
  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    tag_d   = tag_q;
    if (commit_en) begin
      value_d[rf.reg_id] = rf.reg_value;
      if (busy_q[rf.reg_id] && (tag_q[rf.reg_id] == rf.reg_tag)) begin
        busy_d[rf.reg_id] = 1'b0;
      end
    end
    if (clear_en) begin
      busy_d = '0;
    end else if (issue_en) begin
      busy_d[rf.issue_rd_id] = 1'b1;
      tag_d[rf.issue_rd_id]  = rf.issue_tag;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
      busy_q <= '0;
    end else if (rf.rdy_in) begin
      value_q <= value_d;
      busy_q  <= busy_d;
      tag_q   <= tag_d;
    end
  end

  assign rs_id[0] = rf.rs1_id;
  assign rs_id[1] = rf.rs2_id;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p].value = value_q[rs_id[p]];
      rd[p].busy  = busy_q[rs_id[p]];
      rd[p].tag   = tag_q[rs_id[p]];
`ifdef RF_COMMIT_BYPASS_EN
      if (commit_en && (rf.reg_id == rs_id[p]) && busy_q[rs_id[p]] &&
          (tag_q[rs_id[p]] == rf.reg_tag)) begin
        rd[p].value = rf.reg_value;
        rd[p].busy  = 1'b0;
      end
`endif
      if (rs_id[p] == 5'd0) begin
        rd[p] = '0;
      end
    end
  end

  assign rf.rs1_value = rd[0].value;
  assign rf.rs1_busy  = rd[0].busy;
  assign rf.rs1_tag   = rd[0].tag;
  assign rf.rs2_value = rd[1].value;
  assign rf.rs2_busy  = rd[1].busy;
  assign rf.rs2_tag   = rd[1].tag;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: expectations queued as stimulus is driven, popped when read back.
module tb_register_file;
  localparam int RW = 4;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  register_file_if #(.ROB_WIDTH(RW)) rf_if ();

  register_file #(.ROB_WIDTH(RW), .REG_COUNT(32)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rf     (rf_if)
  );

  typedef struct {
    string          name;
    logic [4:0]     id;
    logic [31:0]    value;
    logic           busy;
    logic [RW-1:0]  tag;
    bit             chk_tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  task automatic expect_reg(input string name, input logic [4:0] id, input logic [31:0] value,
                            input logic busy, input logic [RW-1:0] tag, input bit chk_tag);
    exp_t e;
    e.name = name; e.id = id; e.value = value; e.busy = busy; e.tag = tag; e.chk_tag = chk_tag;
    sb.push_back(e);
  endtask

  task automatic idle();
    rf_if.rdy_in       = 1'b1;
    rf_if.clear_signal = 1'b0;
    rf_if.issue_signal = 1'b0;
    rf_if.issue_rd_id  = 5'd0;
    rf_if.issue_tag    = '0;
    rf_if.reg_done     = 1'b0;
    rf_if.reg_value    = 32'd0;
    rf_if.reg_id       = 5'd0;
    rf_if.reg_tag      = '0;
  endtask

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic check_one();
    exp_t e;
    e = sb.pop_front();
    rf_if.rs1_id = e.id;
    rf_if.rs2_id = e.id;
    #1;
    cmp({e.name, ".rs1_value"}, rf_if.rs1_value, e.value);
    cmp({e.name, ".rs1_busy"}, {31'd0, rf_if.rs1_busy}, {31'd0, e.busy});
    cmp({e.name, ".rs2_value"}, rf_if.rs2_value, e.value);
    cmp({e.name, ".rs2_busy"}, {31'd0, rf_if.rs2_busy}, {31'd0, e.busy});
    if (e.chk_tag) begin
      cmp({e.name, ".rs1_tag"}, 32'(rf_if.rs1_tag), 32'(e.tag));
      cmp({e.name, ".rs2_tag"}, 32'(rf_if.rs2_tag), 32'(e.tag));
    end
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      check_one();
      if (sb.size() > 0) @(negedge clk_in);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rf_if.rs1_id = 5'd0;
    rf_if.rs2_id = 5'd0;
    idle();

    // Reset must win even with rdy_in low and a commit pending.
    rst_in          = 1'b0;
    rf_if.rdy_in    = 1'b0;
    rf_if.reg_done  = 1'b1;
    rf_if.reg_id    = 5'd5;
    rf_if.reg_value = 32'hDEAD_BEEF;
    step();
    rst_in = 1'b1;
    idle();
    expect_reg("reset_x5", 5'd5, 32'd0, 1'b0, 4'd0, 1'b1);
    expect_reg("reset_x31", 5'd31, 32'd0, 1'b0, 4'd0, 1'b1);
    expect_reg("reset_x0", 5'd0, 32'd0, 1'b0, 4'd0, 1'b1);
    drain();

    rf_if.reg_done = 1'b1; rf_if.reg_id = 5'd5; rf_if.reg_value = 32'h1234; rf_if.reg_tag = 4'd0;
    expect_reg("commit_idle_x5", 5'd5, 32'h1234, 1'b0, 4'd0, 1'b0);
    step(); idle(); drain();

    // Rename x3; a read in the issue cycle still sees the older mapping.
    rf_if.issue_signal = 1'b1; rf_if.issue_rd_id = 5'd3; rf_if.issue_tag = 4'd7;
    expect_reg("issue_self_read_x3", 5'd3, 32'd0, 1'b0, 4'd0, 1'b1);
    check_one();
    expect_reg("issue_x3", 5'd3, 32'd0, 1'b1, 4'd7, 1'b1);
    step(); idle(); drain();

    rf_if.reg_done = 1'b1; rf_if.reg_id = 5'd3; rf_if.reg_value = 32'hAA; rf_if.reg_tag = 4'd7;
    expect_reg("commit_x3", 5'd3, 32'hAA, 1'b0, 4'd7, 1'b0);
    step(); idle(); drain();

    // Stale commit: value written, younger producer keeps busy/tag.
    rf_if.issue_signal = 1'b1; rf_if.issue_rd_id = 5'd4; rf_if.issue_tag = 4'd2;
    step();
    rf_if.issue_tag = 4'd9;
    step(); idle();
    rf_if.reg_done = 1'b1; rf_if.reg_id = 5'd4; rf_if.reg_value = 32'h55; rf_if.reg_tag = 4'd2;
    expect_reg("stale_commit_x4", 5'd4, 32'h55, 1'b1, 4'd9, 1'b1);
    step(); idle(); drain();
    rf_if.reg_done = 1'b1; rf_if.reg_id = 5'd4; rf_if.reg_value = 32'h66; rf_if.reg_tag = 4'd9;
    expect_reg("fresh_commit_x4", 5'd4, 32'h66, 1'b0, 4'd9, 1'b0);
    step(); idle(); drain();

    // Same-cycle commit (matching tag) and re-issue of x6: issue wins busy/tag.
    rf_if.issue_signal = 1'b1; rf_if.issue_rd_id = 5'd6; rf_if.issue_tag = 4'd1;
    step(); idle();
    rf_if.issue_signal = 1'b1; rf_if.issue_rd_id = 5'd6; rf_if.issue_tag = 4'd5;
    rf_if.reg_done = 1'b1; rf_if.reg_id = 5'd6; rf_if.reg_value = 32'hC0DE; rf_if.reg_tag = 4'd1;
    expect_reg("commit_issue_x6", 5'd6, 32'hC0DE, 1'b1, 4'd5, 1'b1);
    step(); idle(); drain();

    // Flush with a commit and an issue in the same cycle.
    rf_if.issue_signal = 1'b1; rf_if.issue_rd_id = 5'd1; rf_if.issue_tag = 4'd11;
    step();
    rf_if.issue_rd_id = 5'd2; rf_if.issue_tag = 4'd12;
    step(); idle();
    expect_reg("pre_flush_x1", 5'd1, 32'd0, 1'b1, 4'd11, 1'b1);
    expect_reg("pre_flush_x2", 5'd2, 32'd0, 1'b1, 4'd12, 1'b1);
    drain();
    rf_if.clear_signal = 1'b1;
    rf_if.reg_done = 1'b1; rf_if.reg_id = 5'd1; rf_if.reg_value = 32'h100; rf_if.reg_tag = 4'd0;
    rf_if.issue_signal = 1'b1; rf_if.issue_rd_id = 5'd2; rf_if.issue_tag = 4'd3;
    expect_reg("flush_x1", 5'd1, 32'h100, 1'b0, 4'd0, 1'b0);
    expect_reg("flush_x2", 5'd2, 32'd0, 1'b0, 4'd0, 1'b0);
    expect_reg("flush_x6", 5'd6, 32'hC0DE, 1'b0, 4'd0, 1'b0);
    step(); idle(); drain();

    rf_if.reg_done = 1'b1; rf_if.reg_id = 5'd0; rf_if.reg_value = 32'hFF;
    rf_if.issue_signal = 1'b1; rf_if.issue_rd_id = 5'd0; rf_if.issue_tag = 4'd4;
    expect_reg("x0_write", 5'd0, 32'd0, 1'b0, 4'd0, 1'b1);
    step(); idle(); drain();

    // rdy_in low freezes issue and commit alike.
    rf_if.rdy_in = 1'b0;
    rf_if.issue_signal = 1'b1; rf_if.issue_rd_id = 5'd8; rf_if.issue_tag = 4'd4;
    rf_if.reg_done = 1'b1; rf_if.reg_id = 5'd5; rf_if.reg_value = 32'hBAD;
    expect_reg("freeze_x8", 5'd8, 32'd0, 1'b0, 4'd0, 1'b1);
    expect_reg("freeze_x5", 5'd5, 32'h1234, 1'b0, 4'd0, 1'b0);
    step(); idle(); drain();

    // Same-cycle commit seen by the read ports.
    rf_if.issue_signal = 1'b1; rf_if.issue_rd_id = 5'd3; rf_if.issue_tag = 4'd7;
    step(); idle();
    rf_if.reg_done = 1'b1; rf_if.reg_id = 5'd3; rf_if.reg_value = 32'h66; rf_if.reg_tag = 4'd6;
    expect_reg("bypass_tag_miss_x3", 5'd3, 32'hAA, 1'b1, 4'd7, 1'b1);
    check_one();
    rf_if.reg_value = 32'h77; rf_if.reg_tag = 4'd7;
`ifdef RF_COMMIT_BYPASS_EN
    expect_reg("bypass_hit_x3", 5'd3, 32'h77, 1'b0, 4'd7, 1'b0);
`else
    expect_reg("no_bypass_x3", 5'd3, 32'hAA, 1'b1, 4'd7, 1'b1);
`endif
    check_one();
    expect_reg("post_bypass_x3", 5'd3, 32'h77, 1'b0, 4'd7, 1'b0);
    step(); idle(); drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural register file with rename tags. Sits beside the reorder buffer: it consumes the ROB's register-commit stream (reg_done/reg_value/reg_id/reg_tag) and the ROB's clear_signal.
- At issue it supplies instruction fetch with the operand value or the ROB tag of each source register, then records the new ROB tag for rd.
- 32 x 32-bit registers; x0 hardwired to zero.

Parameters:
ROB_WIDTH, 4, width of ROB tags (ROB holds 2**ROB_WIDTH entries)
REG_COUNT, 32, number of architectural registers (fixed; index width 5)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous reset, active-low
rdy_in  input  1  global ready; state frozen when low
clear_signal  input  1  ROB misprediction flush
issue_signal  input  1  instruction issued this cycle
issue_rd_id  input  5  destination register of issued instruction
issue_tag  input  ROB_WIDTH  ROB entry allocated to issued instruction
rs1_id  input  5  source register 1 index
rs2_id  input  5  source register 2 index
rs1_value  output  32  register value (valid when rs1_busy=0)
rs2_value  output  32  register value (valid when rs2_busy=0)
rs1_busy  output  1  1 = value pending in ROB
rs2_busy  output  1  1 = value pending in ROB
rs1_tag  output  ROB_WIDTH  producing ROB tag (valid when rs1_busy=1)
rs2_tag  output  ROB_WIDTH  producing ROB tag (valid when rs2_busy=1)
reg_done  input  1  ROB commit to RF
reg_value  input  32  committed value
reg_id  input  5  committed rd
reg_tag  input  ROB_WIDTH  ROB tag of committing entry

Behaviour:
- State per register:
  - value[i]: 32 bits
  - busy[i]: 1 bit
  - tag[i]: ROB_WIDTH bits
- Reset: sampled on posedge clk_in when rst_in==0, regardless of rdy_in.
  - All value, busy and tag cleared.
  - Outputs therefore read value 0, busy 0, tag 0.
- Freeze: when rdy_in==0 (and not in reset), no state changes.
- Read ports are combinational from current state.
  - rsN_id==0 gives value 0, busy 0, tag 0.
  - Reads reflect the state before this cycle's issue. An instruction whose rs equals its own rd sees the older mapping.
- Commit (posedge, rdy_in=1, reg_done=1, reg_id!=0):
  - value[reg_id] <= reg_value, always, including when clear_signal=1. A JALR commit carries its link value in the same cycle it raises clear.
  - busy[reg_id] <= 0 only if busy[reg_id]==1, tag[reg_id]==reg_tag, and the same-cycle issue is not renaming reg_id.
  - A tag mismatch means a younger producer owns rd: value is still written, busy/tag untouched.
- Issue (posedge, rdy_in=1, issue_signal=1, clear_signal=0, issue_rd_id!=0):
  - busy[issue_rd_id] <= 1
  - tag[issue_rd_id] <= issue_tag
  - Issue has priority over commit on busy/tag for the same register.
  - Issue with rd=0 changes nothing.
- Clear (posedge, rdy_in=1, clear_signal=1):
  - All busy <= 0; tags are don't-care.
  - Issue is ignored that cycle.
  - Commit value write still occurs.
- Writes to x0 are ignored everywhere.
- No internal pipeline; every update takes effect in 1 cycle.

Optional Feature:
- Macro: RF_COMMIT_BYPASS_EN.
- Defined: read ports forward a same-cycle commit when all of the following hold:
  - reg_done=1 and rdy_in=1
  - reg_id==rsN_id!=0
  - busy[rsN_id]=1 and tag[rsN_id]==reg_tag
- Forwarding result: rsN_busy=0 and rsN_value=reg_value.
- Not defined: reads show registered state only; the instruction receives the tag and the ROB/RS broadcast supplies the value.

Test Plan:
- Reset: rst_in=0 for 1 cycle, then read x5 -> value 0, busy 0. Commit reg_id=5, value 0x1234 with x5 not busy -> next cycle rs1_value=0x1234, busy 0.
- Rename then commit: issue rd=3, tag=7 -> next cycle rs1(x3) busy=1, tag=7. Commit reg_id=3, tag=7, value 0xAA -> busy=0, value 0xAA.
- Stale commit: issue rd=4 tag=2, then issue rd=4 tag=9, then commit reg_id=4 tag=2 value 0x55 -> value 0x55, busy=1, tag=9. Commit tag=9 value 0x66 -> busy 0, value 0x66.
- Simultaneous commit and issue to x6 (commit tag=1, issue tag=5) -> value = committed value, busy=1, tag=5.
- Flush: x1, x2 busy; clear_signal=1 with reg_done=1, reg_id=1, value 0x100 and issue rd=2 tag=3 -> x1 value 0x100; x1 and x2 busy=0; x2 tag not updated.
- x0 and rdy_in: commit reg_id=0 value 0xFF -> x0 reads 0. With rdy_in=0, issue rd=8 -> x8 busy stays 0. With RF_COMMIT_BYPASS_EN, busy x3 tag 7 + same-cycle commit tag 7 value 0x77 -> rs1 reads busy 0, value 0x77 combinationally.
